dmem_load_store: RTL and testbench

- Byte-addressable data memory feeding the load-extraction stage, which sign- or zero-extends a byte, halfword or word taken from bits [7:0], [15:0] or [31:0].
- Performs store byte-lane merging (SB/SH/SW) on the clock edge.
- Returns the addressed word right-justified: the selected byte or halfword appears in bit 0 upward, ready for extraction.
- Detects misaligned and out-of-range accesses, and suppresses them.

---
 rtl/dmem_load_store.sv | 102 ++++++++++
 tb/tb_dmem_load_store.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_load_store.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_load_store
//  Description : Byte-addressable data memory with SB/SH/SW lane merging,
//                zero-latency right-justified read, alignment/range checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_store #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic [2:0]  st_type,
    input  logic [31:0] st_data,
    input  logic        rd_en,
    input  logic [2:0]  ld_type,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        addr_err
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_SPAN  = 32'(4 * DEPTH_WORDS);

    logic [31:0]        w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_lane;
    logic               w_is_half;
    logic               w_is_word;
    logic               w_st_valid;
    logic               w_misalign;
    logic               w_addr_err;
    logic               w_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_word;

    assign w_off  = addr - BASE_ADDR;
    assign w_idx  = w_off[c_IDX_W+1:2];
    assign w_lane = addr[1:0];

    // A store takes precedence over a load when both are requested.
    always_comb begin
        w_is_half = 1'b0;
        w_is_word = 1'b0;
        if (wr_en) begin
            w_is_half = (st_type == 3'b001);
            w_is_word = (st_type == 3'b010);
        end else if (rd_en) begin
            w_is_half = (ld_type == 3'b001) || (ld_type == 3'b101);
            w_is_word = (ld_type == 3'b010);
        end
    end

    assign w_st_valid = (st_type == 3'b000) || (st_type == 3'b001) || (st_type == 3'b010);
    assign w_misalign = (w_is_half && addr[0]) || (w_is_word && (addr[1:0] != 2'b00));
    assign w_addr_err = (wr_en || rd_en) && ((addr < BASE_ADDR) || (w_off >= c_SPAN));
    assign w_we       = wr_en && !rst && w_st_valid && !w_misalign && !w_addr_err;

    always_comb begin
        case (st_type)
            3'b000:  w_be = 4'b0001 << w_lane;
            3'b001:  w_be = 4'b0011 << w_lane;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_wdata = st_data << {w_lane, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (w_we && w_be[gi]) begin
                    r_mem[w_idx] <= w_wdata[8*gi +: 8];
                end
            end

            assign w_word[8*gi +: 8] = r_mem[w_idx];
        end
    endgenerate

    always_comb begin
        load_data = 32'h0;
        misalign  = 1'b0;
        addr_err  = 1'b0;
        if (!rst) begin
            misalign = w_misalign;
            addr_err = w_addr_err;
            if (rd_en && !w_misalign && !w_addr_err) begin
                load_data = w_word >> {w_lane, 3'b000};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_load_store.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_load_store
//  Description : Self-checking bench for dmem_load_store against a byte-array
//                reference model with directed and randomized accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_load_store;

    localparam int unsigned c_DEPTH = 2048;
    localparam logic [31:0] c_BASE  = 32'h0000_2000;
    localparam longint      c_SPAN  = 4 * c_DEPTH;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        wr_en;
    logic [2:0]  st_type;
    logic [31:0] st_data;
    logic        rd_en;
    logic [2:0]  ld_type;
    logic [31:0] load_data;
    logic        misalign;
    logic        addr_err;

    dmem_load_store #(
        .DEPTH_WORDS (c_DEPTH),
        .BASE_ADDR   (c_BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wr_en     (wr_en),
        .st_type   (st_type),
        .st_data   (st_data),
        .rd_en     (rd_en),
        .ld_type   (ld_type),
        .load_data (load_data),
        .misalign  (misalign),
        .addr_err  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  bmem [c_SPAN];
    logic [31:0] obs_ld;
    logic        obs_mis;
    logic        obs_aerr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Byte-level reference: compute expected outputs, check, then commit any store.
    task automatic apply(input string tag, input logic r, input logic w, input logic [2:0] st,
                         input logic [31:0] sd, input logic rd, input logic [2:0] ld,
                         input logic [31:0] a);
        longint      off;
        int          sz;
        int          wb;
        logic        mis;
        logic        aerr;
        logic [31:0] word;
        logic [31:0] ld_exp;
        @(negedge clk);
        rst = r; wr_en = w; st_type = st; st_data = sd; rd_en = rd; ld_type = ld; addr = a;
        off  = longint'(a) - longint'(c_BASE);
        aerr = (w || rd) && (off < 0 || off >= c_SPAN);
        sz   = 0;
        if (w) begin
            case (st)
                3'd0:    sz = 1;
                3'd1:    sz = 2;
                3'd2:    sz = 4;
                default: sz = 0;
            endcase
        end else if (rd) begin
            case (ld)
                3'd0, 3'd4: sz = 1;
                3'd1, 3'd5: sz = 2;
                3'd2:       sz = 4;
                default:    sz = 0;
            endcase
        end
        mis    = (sz == 2 && (off % 2) != 0) || (sz == 4 && (off % 4) != 0);
        ld_exp = 32'h0;
        if (rd && !mis && !aerr) begin
            wb     = int'(off) - int'(off % 4);
            word   = {bmem[wb+3], bmem[wb+2], bmem[wb+1], bmem[wb]};
            ld_exp = word >> (8 * int'(off % 4));
        end
        if (r) begin
            mis    = 1'b0;
            aerr   = 1'b0;
            ld_exp = 32'h0;
        end
        #1;
        obs_ld   = load_data;
        obs_mis  = misalign;
        obs_aerr = addr_err;
        check_eq({tag, ".load_data"}, load_data, ld_exp);
        check_eq({tag, ".misalign"}, {31'b0, misalign}, {31'b0, mis});
        check_eq({tag, ".addr_err"}, {31'b0, addr_err}, {31'b0, aerr});
        @(posedge clk);
        if (!r && w && sz > 0 && !mis && !aerr) begin
            for (int k = 0; k < sz; k++) bmem[int'(off) + k] = sd[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return c_BASE - 32'($urandom_range(1, 16));
            1:       return c_BASE + 32'(c_SPAN) + 32'($urandom_range(0, 15));
            2:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            3, 4:    return c_BASE + 32'(c_SPAN) - 32'($urandom_range(1, 32));
            default: return c_BASE + 32'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        logic [2:0] st_r;
        logic [2:0] ld_r;
        rst = 1'b1; wr_en = 1'b0; st_type = 3'd0; st_data = 32'h0;
        rd_en = 1'b0; ld_type = 3'd0; addr = 32'h0;

        // Reset: outputs held at zero even with an in-range load and an out-of-range store.
        apply("rst_ld", 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, c_BASE);
        apply("rst_st", 1'b1, 1'b1, 3'd2, 32'h0, 1'b0, 3'd0, 32'h0000_1000);

        // Give every word a known value so the model fully covers the array.
        for (int i = 0; i < int'(c_DEPTH); i++)
            apply("fill", 1'b0, 1'b1, 3'd2, $urandom, 1'b0, 3'd0, c_BASE + 32'(4 * i));

        apply("t1_sw", 1'b0, 1'b1, 3'd2, 32'hFF0000A0, 1'b0, 3'd0, 32'h2000);
        apply("t1_lb", 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 32'h2000);
        check_eq("t1_lb_lit", obs_ld, 32'hFF0000A0);

        apply("t2_sw",  1'b0, 1'b1, 3'd2, 32'h12345678, 1'b0, 3'd0, 32'h2000);
        apply("t2_sb",  1'b0, 1'b1, 3'd0, 32'hAAAAAA3C, 1'b0, 3'd0, 32'h2001);
        apply("t2_lw",  1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h2000);
        check_eq("t2_lw_lit", obs_ld, 32'h12343C78);
        apply("t2_lbu", 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd4, 32'h2001);
        check_eq("t2_lbu_lit", obs_ld, 32'h0012343C);

        apply("t3_sw",  1'b0, 1'b1, 3'd2, 32'hF1230000, 1'b0, 3'd0, 32'h2004);
        apply("t3_sh",  1'b0, 1'b1, 3'd1, 32'h5555BCDE, 1'b0, 3'd0, 32'h2006);
        apply("t3_lw",  1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h2004);
        check_eq("t3_lw_lit", obs_ld, 32'hBCDE0000);
        apply("t3_lhu", 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd5, 32'h2006);
        check_eq("t3_lhu_lit", obs_ld, 32'h0000BCDE);

        apply("t4_lw",  1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h2002);
        check_eq("t4_lw_mis", {31'b0, obs_mis}, 32'd1);
        apply("t4_sh",  1'b0, 1'b1, 3'd1, 32'h0000FFFF, 1'b0, 3'd0, 32'h2003);
        check_eq("t4_sh_mis", {31'b0, obs_mis}, 32'd1);
        apply("t4_rb",  1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h2000);
        check_eq("t4_rb_lit", obs_ld, 32'h12343C78);

        apply("t5_lo",  1'b0, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 3'd0, 32'h1FFC);
        check_eq("t5_lo_err", {31'b0, obs_aerr}, 32'd1);
        apply("t5_hi",  1'b0, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 3'd0, c_BASE + 32'h2000);
        check_eq("t5_hi_err", {31'b0, obs_aerr}, 32'd1);
        apply("t5_w0",  1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h2000);
        check_eq("t5_w0_lit", obs_ld, 32'h12343C78);
        apply("t5_wtop", 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, c_BASE + 32'h1FFC);

        apply("t6_pre", 1'b0, 1'b1, 3'd2, 32'h0BADF00D, 1'b0, 3'd0, 32'h2010);
        apply("t6_rdw", 1'b0, 1'b1, 3'd2, 32'hACBDEFAB, 1'b1, 3'd2, 32'h2010);
        check_eq("t6_rdw_old", obs_ld, 32'h0BADF00D);
        apply("t6_new", 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h2010);
        check_eq("t6_new_lit", obs_ld, 32'hACBDEFAB);
        apply("t6_rst", 1'b1, 1'b1, 3'd2, 32'h0, 1'b1, 3'd2, 32'h2010);
        check_eq("t6_rst_ld", obs_ld, 32'h0);
        apply("t6_post", 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h2010);
        check_eq("t6_post_lit", obs_ld, 32'hACBDEFAB);

        for (int i = 0; i < 600; i++) begin
            st_r = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            ld_r = 3'($urandom_range(0, 7));
            apply("rnd", ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0), st_r,
                  $urandom, ($urandom_range(0, 3) != 0), ld_r, rand_addr());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
